// File: rtl/if_fetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage:
// the fetch FSM state encoding, the default PC step, and a word-alignment helper.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEFAULT = 4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one request in flight, hold buffer for downstream
// freezes, and drain of the stale request after a branch redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [31:0]  branch_addr,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic         valid_out,
  output logic [31:0]  pc_out,
  output logic [31:0]  instruction_out,
  output fetch_state_e state_dbg
);

  // Memory handshake: a transfer happens in any cycle with imem_req=1 and
  // imem_ready=1; while imem_req=1 and imem_ready=0 the address is held and
  // the request is never withdrawn.
  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic         active_q, active_d;

  logic [31:0]  pc_next;
  logic [31:0]  br_tgt;

  assign pc_next   = pc_q + STEP;
  assign br_tgt    = align_word(branch_addr);
  assign state_dbg = state_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    tgt_d           = tgt_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    active_d        = 1'b1;
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    valid_out       = 1'b0;
    pc_out          = 32'h0;
    instruction_out = 32'h0;

    // active_q keeps the stage idle until the first edge after reset release.
    if (active_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (branch_taken) begin
              pc_d = br_tgt;
            end else begin
              valid_out       = 1'b1;
              instruction_out = imem_rdata;
              pc_out          = pc_next;
              if (freeze) begin
                hold_instr_d = imem_rdata;
                hold_pc_d    = pc_next;
                state_d      = ST_HOLD;
              end else begin
                pc_d = pc_next;
              end
            end
          end else if (branch_taken) begin
            tgt_d   = br_tgt;
            state_d = ST_DISCARD;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            pc_d         = br_tgt;
            hold_instr_d = 32'h0;
            hold_pc_d    = 32'h0;
            state_d      = ST_FETCH;
          end else begin
            valid_out       = 1'b1;
            instruction_out = hold_instr_q;
            pc_out          = hold_pc_q;
            if (!freeze) begin
              pc_d    = pc_next;
              state_d = ST_FETCH;
            end
          end
        end
        ST_DISCARD: begin
          imem_req = 1'b1;
          if (branch_taken) begin
            tgt_d = br_tgt;
          end
          if (imem_ready) begin
            pc_d    = branch_taken ? br_tgt : tgt_q;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      active_q     <= active_d;
    end
  end

endmodule
